dff_sync_debounce: RTL

- Input-conditioning stage that sits directly upstream of the team's D flip-flop blocks.
- Takes a raw asynchronous or bouncy level input.
- Passes it through a flip-flop synchronizer chain, then a counter-based debounce filter.
- Delivers a clean registered level plus single-cycle rise/fall strobes that downstream DFF/register stages consume as their d input or enable.

---
 rtl/dff_sync_debounce.sv | 88 ++++++++
 1 files changed

// File: rtl/dff_sync_debounce.sv
// Input conditioner: a flip-flop synchronizer chain followed by a counter-based
// debounce filter, producing a clean level q plus one-cycle rise/fall strobes.
module dff_sync_debounce #(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_COUNT = 50000,
  parameter int CNT_WIDTH    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("dff_sync_debounce: SYNC_STAGES must be 2 or more");
    end
    if (STABLE_COUNT < 1 || CNT_WIDTH < 1 ||
        ((longint'(STABLE_COUNT) - 64'sd1) >>> CNT_WIDTH) != 64'sd0) begin : g_bad_cnt
      $error("dff_sync_debounce: CNT_WIDTH cannot hold STABLE_COUNT-1");
    end
  endgenerate

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  typedef enum logic {STABLE, VERIFY} state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   ds;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   cnt_nxt;
  logic                   q_nxt;
  logic                   rise_nxt;
  logic                   fall_nxt;
  logic                   qualify;
  state_t                 state;

  assign ds      = sync[SYNC_STAGES-1];
  // The state is fully implied by the counter; the enum only names it.
  assign state   = (cnt == '0) ? STABLE : VERIFY;
  assign qualify = (ds != q) && (cnt == LAST);

  always_comb begin
    cnt_nxt  = cnt;
    q_nxt    = q;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    if (qualify) begin
      q_nxt    = ds;
      cnt_nxt  = '0;
      rise_nxt = ds;
      fall_nxt = ~ds;
    end else begin
      case (state)
        STABLE: if (ds != q) cnt_nxt = ONE;
        VERIFY: begin
          if (ds == q) cnt_nxt = '0;
          else         cnt_nxt = cnt + ONE;
        end
        default: cnt_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      cnt  <= '0;
      q    <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
      busy <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      cnt  <= cnt_nxt;
      q    <= q_nxt;
      rise <= rise_nxt;
      fall <= fall_nxt;
      // Registered copy of (cnt != 0), aligned with the counter itself.
      busy <= (cnt_nxt != '0);
    end
  end

endmodule
